ecall_halt_unit: RTL and testbench

Pipeline-control block in the ID stage that turns an `ecall` into a clean processor halt. It consumes the x17 value delivered by the ID-stage forwarding mux. It waits while x17 is not yet forwardable, then decides halt/no-halt. On halt it freezes fetch and drains older instructions, raising `is_halted` once the ecall has retired through WB. It drives the PC/IF-ID stall and the ID/EX bubble controls alongside the hazard unit; its outputs are OR-ed with the hazard unit's outputs.

---
 rtl/ecall_halt_unit.sv | 106 ++++++++++
 tb/tb_ecall_halt_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ecall_halt_unit.sv
// ID-stage ecall handler: waits out x17 hazards, decides halt, then freezes fetch
// and drains older instructions until the ecall has retired through WB.
module ecall_halt_unit #(
  parameter logic [31:0] HALT_CODE    = 32'd10,
  parameter int unsigned ECALL_REG    = 17,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_is_ecall,
  input  logic [31:0] i_x17_value,
  input  logic [4:0]  i_id_ex_rd,
  input  logic        i_id_ex_reg_write,
  input  logic [4:0]  i_ex_mem_rd,
  input  logic        i_ex_mem_mem_read,
  output logic        o_pc_stall,
  output logic        o_id_ex_flush,
  output logic        o_halt_pending,
  output logic        o_is_halted
);

  localparam int unsigned CW  = $clog2(DRAIN_CYCLES + 1);
  localparam logic [4:0]  REG = 5'(ECALL_REG);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            w_hz;
  logic            w_halt_req;

  // x0 is never written, so an x0 ecall register can never be pending.
  assign w_hz = (REG != 5'd0) &&
                ((i_id_ex_reg_write && (i_id_ex_rd == REG)) ||
                 (i_ex_mem_mem_read && (i_ex_mem_rd == REG)));
  assign w_halt_req = (i_x17_value == HALT_CODE);

  always_comb begin
    o_pc_stall     = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_halt_pending = 1'b0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        // On the halt decision the ecall itself must still enter ID/EX.
        if (i_is_ecall) begin
          if (w_hz) begin
            o_pc_stall    = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (w_halt_req) begin
            o_pc_stall    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        o_pc_stall     = 1'b1;
        o_id_ex_flush  = 1'b1;
        o_halt_pending = 1'b1;
      end
      S_HALTED: begin
        o_pc_stall    = 1'b1;
        o_id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    if (i_reset) begin
      o_pc_stall     = 1'b0;
      o_id_ex_flush  = 1'b0;
      o_halt_pending = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      o_is_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (!i_is_ecall) begin
            r_state <= S_IDLE;
          end else if (w_hz) begin
            r_state <= S_WAIT;
          end else if (w_halt_req) begin
            r_state <= S_DRAIN;
            r_cnt   <= CW'(DRAIN_CYCLES);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CW'(1)) begin
            r_state     <= S_HALTED;
            r_cnt       <= '0;
            o_is_halted <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecall_halt_unit.sv
// Randomized + directed bench for ecall_halt_unit against a cycle-age reference model.
module tb_ecall_halt_unit;

  localparam logic [31:0] HALT_CODE    = 32'd10;
  localparam int          ECALL_REG    = 17;
  localparam int          DRAIN_CYCLES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_ecall;
  logic [31:0] x17_value;
  logic [4:0]  id_ex_rd;
  logic        id_ex_reg_write;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_mem_read;
  logic        pc_stall, id_ex_flush, halt_pending, is_halted;

  int n_chk  = 0;
  int n_fail = 0;
  // Posedges since the halt decision edge (0 = no halt in progress).
  int age    = 0;

  always #5 clk = ~clk;

  ecall_halt_unit #(
    .HALT_CODE(HALT_CODE), .ECALL_REG(ECALL_REG), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_is_ecall(is_ecall), .i_x17_value(x17_value),
    .i_id_ex_rd(id_ex_rd), .i_id_ex_reg_write(id_ex_reg_write),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_mem_read(ex_mem_mem_read),
    .o_pc_stall(pc_stall), .o_id_ex_flush(id_ex_flush),
    .o_halt_pending(halt_pending), .o_is_halted(is_halted)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs, then advance model across posedge.
  task automatic step(input logic ec, input logic [31:0] x, input logic exw,
                      input logic [4:0] exrd, input logic ld, input logic [4:0] memrd,
                      input logic rst);
    logic hz, hreq, busy;
    logic e_stall, e_flush, e_pend, e_halt;
    @(negedge clk);
    reset = rst; is_ecall = ec; x17_value = x;
    id_ex_reg_write = exw; id_ex_rd = exrd; ex_mem_mem_read = ld; ex_mem_rd = memrd;
    #1;
    if (rst) age = 0;
    hz   = (exw && exrd == 5'(ECALL_REG)) || (ld && memrd == 5'(ECALL_REG));
    hreq = (x == HALT_CODE);
    busy = (age > 0);
    e_halt  = !rst && (age > DRAIN_CYCLES);
    e_pend  = !rst && busy && !e_halt;
    e_stall = !rst && (busy || (ec && (hz || hreq)));
    e_flush = !rst && (busy || (ec && hz));
    chk("pc_stall",     pc_stall,     e_stall);
    chk("id_ex_flush",  id_ex_flush,  e_flush);
    chk("halt_pending", halt_pending, e_pend);
    chk("is_halted",    is_halted,    e_halt);
    if (!rst) begin
      if (busy) age++;
      else if (ec && !hz && hreq) age = 1;
    end
  endtask

  task automatic idle_n(input int n, input logic ec, input logic [31:0] x);
    for (int i = 0; i < n; i++) step(ec, x, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 32'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 32'd0,  1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] xv;
    reset = 1'b1; is_ecall = 1'b0; x17_value = '0;
    id_ex_rd = '0; id_ex_reg_write = 1'b0; ex_mem_rd = '0; ex_mem_mem_read = 1'b0;
    do_reset();

    // No hazard, x17 forwarded as 10: halt at cycle 4.
    idle_n(6, 1'b1, 32'd10);
    do_reset();
    // Load of x17 in MEM: one WAIT cycle.
    step(1'b1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd17, 1'b0);
    idle_n(6, 1'b1, 32'd10);
    do_reset();
    // addi x17 in EX, then the load in MEM: two WAIT cycles.
    step(1'b1, 32'd0, 1'b1, 5'd17, 1'b0, 5'd0, 1'b0);
    step(1'b1, 32'd0, 1'b0, 5'd0,  1'b1, 5'd17, 1'b0);
    idle_n(6, 1'b1, 32'd10);
    do_reset();
    // Non-load MEM writer and non-17 EX writer are not hazards.
    step(1'b1, 32'd93, 1'b1, 5'd16, 1'b0, 5'd17, 1'b0);
    // x17=93: nop ecall, then a real halt.
    idle_n(3, 1'b1, 32'd93);
    idle_n(3, 1'b0, 32'd10);
    idle_n(2, 1'b1, 32'd10);
    // Reset at drain cycle 2 aborts.
    do_reset();
    idle_n(4, 1'b0, 32'd10);
    // Full-width compare.
    idle_n(2, 1'b1, 32'h1000_000A);
    idle_n(6, 1'b1, 32'h0000_000A);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: xv = HALT_CODE;
        1: xv = 32'd93;
        2: xv = 32'h1000_000A;
        default: xv = $urandom;
      endcase
      step($urandom_range(3) != 0, xv,
           $urandom_range(2) == 0, ($urandom_range(1) == 0) ? 5'd17 : 5'($urandom),
           $urandom_range(2) == 0, ($urandom_range(1) == 0) ? 5'd17 : 5'($urandom),
           ($urandom_range(39) == 0) || (age > DRAIN_CYCLES + 2 && $urandom_range(3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
